// File: rtl/clock_display_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module : clock_display_scan_pkg
// Desc   : Shared types, segment patterns and digit indices for the HH:MM:SS
//          multiplexed 7-segment scanner.
// Rev    : 1.0  initial release
// ============================================================================
package clock_display_scan_pkg;

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_GUARD = 2'd1,
      S_DRIVE = 2'd2
   } state_t;

   // Active-high patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   localparam logic [2:0] DIG_HH_T = 3'd0;
   localparam logic [2:0] DIG_HH_U = 3'd1;
   localparam logic [2:0] DIG_MM_T = 3'd2;
   localparam logic [2:0] DIG_MM_U = 3'd3;
   localparam logic [2:0] DIG_SS_T = 3'd4;
   localparam logic [2:0] DIG_SS_U = 3'd5;

   localparam logic [7:0] RST_HH = 8'h12;
   localparam logic [7:0] RST_MM = 8'h00;
   localparam logic [7:0] RST_SS = 8'h00;

   function automatic logic [3:0] digit_nibble(
      input logic [7:0] hh,
      input logic [7:0] mm,
      input logic [7:0] ss,
      input logic [2:0] idx
   );
      logic [3:0] nib;
      nib = 4'h0;
      case (idx)
         DIG_HH_T: nib = hh[7:4];
         DIG_HH_U: nib = hh[3:0];
         DIG_MM_T: nib = mm[7:4];
         DIG_MM_U: nib = mm[3:0];
         DIG_SS_T: nib = ss[7:4];
         DIG_SS_U: nib = ss[3:0];
         default:  nib = 4'h0;
      endcase
      return nib;
   endfunction

   // blink_en bit order is {HH,MM,SS}
   function automatic logic field_blink(
      input logic [2:0] blink_en,
      input logic [2:0] idx
   );
      logic bl;
      bl = 1'b0;
      case (idx)
         DIG_HH_T, DIG_HH_U: bl = blink_en[2];
         DIG_MM_T, DIG_MM_U: bl = blink_en[1];
         DIG_SS_T, DIG_SS_U: bl = blink_en[0];
         default:            bl = 1'b0;
      endcase
      return bl;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clock_display_scan_if.sv
`default_nettype none
// ============================================================================
// Module : clock_display_scan_if
// Desc   : Time inputs and display pins of the scanner, grouped as one bundle.
// Rev    : 1.0  initial release
// ============================================================================
interface clock_display_scan_if;
   logic [7:0] i_hh;
   logic [7:0] i_mm;
   logic [7:0] i_ss;
   logic       i_colon;
   logic [2:0] i_blink_en;
   logic       i_blink_tick;
   logic [6:0] o_seg;
   logic       o_dp;
   logic [5:0] o_an;
   logic       o_frame_start;

   modport master (
      output i_hh, i_mm, i_ss, i_colon, i_blink_en, i_blink_tick,
      input  o_seg, o_dp, o_an, o_frame_start
   );

   modport slave (
      input  i_hh, i_mm, i_ss, i_colon, i_blink_en, i_blink_tick,
      output o_seg, o_dp, o_an, o_frame_start
   );
endinterface
`default_nettype wire

// File: rtl/clock_display_scan_bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module : bcd_to_seg7
// Desc   : Combinational BCD nibble to active-high 7-segment pattern; non-BCD
//          codes show a dash.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_to_seg7
   import clock_display_scan_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/clock_display_scan.sv
`default_nettype none
// ============================================================================
// Module : clock_display_scan
// Desc   : Six-digit HH:MM:SS 7-segment scanner with per-frame snapshot,
//          leading-zero blanking, field blink, colon DPs and inter-digit guard.
// Rev    : 1.0  initial release
// ============================================================================
module clock_display_scan
   import clock_display_scan_pkg::*;
#(
   parameter int REFRESH_DIV    = 50000,
   parameter int GUARD_CYC      = 8,
   parameter int LZB            = 1,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   clock_display_scan_if.slave  disp
);

   localparam bit          HAS_GUARD  = (GUARD_CYC != 0);
   localparam logic [31:0] DRIVE_LAST = 32'(REFRESH_DIV - 1);
   localparam logic [31:0] GUARD_LAST = HAS_GUARD ? 32'(GUARD_CYC - 1) : 32'd0;
   localparam logic [6:0]  SEG_XOR    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic        DP_XOR     = (SEG_ACTIVE_LOW != 0);
   localparam logic [5:0]  AN_XOR     = (AN_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

   state_t      state, state_nx;
   logic [2:0]  idx, idx_nx;
   logic [31:0] div, div_nx;

   logic [7:0]  snap_hh, snap_mm, snap_ss;
   logic        blink_phase;

   logic [3:0]  nibble;
   logic [6:0]  pattern;
   logic        blank;
   logic        driving;
   logic [6:0]  seg_nx;
   logic        dp_nx;
   logic [5:0]  an_nx;
   logic        frame_nx;

   logic [6:0]  seg_q;
   logic        dp_q;
   logic [5:0]  an_q;
   logic        frame_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state <= S_LOAD;
         idx   <= DIG_HH_T;
         div   <= 32'd0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         div   <= div_nx;
      end
   end

   // The divider restarts on every phase change so each frame is exactly
   // 1 + 6*(GUARD_CYC+REFRESH_DIV) cycles.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      div_nx   = div;
      case (state)
         S_LOAD: begin
            div_nx   = 32'd0;
            idx_nx   = DIG_HH_T;
            state_nx = HAS_GUARD ? S_GUARD : S_DRIVE;
         end
         S_GUARD: begin
            if (div == GUARD_LAST) begin
               div_nx   = 32'd0;
               state_nx = S_DRIVE;
            end else begin
               div_nx = div + 32'd1;
            end
         end
         S_DRIVE: begin
            if (div == DRIVE_LAST) begin
               div_nx = 32'd0;
               if (idx < DIG_SS_U) begin
                  idx_nx   = idx + 3'd1;
                  state_nx = HAS_GUARD ? S_GUARD : S_DRIVE;
               end else begin
                  idx_nx   = DIG_HH_T;
                  state_nx = S_LOAD;
               end
            end else begin
               div_nx = div + 32'd1;
            end
         end
         default: begin
            state_nx = S_LOAD;
            idx_nx   = DIG_HH_T;
            div_nx   = 32'd0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         snap_hh <= RST_HH;
         snap_mm <= RST_MM;
         snap_ss <= RST_SS;
      end else if (state == S_LOAD) begin
         snap_hh <= disp.i_hh;
         snap_mm <= disp.i_mm;
         snap_ss <= disp.i_ss;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         blink_phase <= 1'b0;
      end else if (disp.i_blink_tick) begin
         blink_phase <= ~blink_phase;
      end
   end

   assign nibble = digit_nibble(snap_hh, snap_mm, snap_ss, idx);

   bcd_to_seg7 u_dec (
      .bcd (nibble),
      .seg (pattern)
   );

   always_comb begin
      driving  = (state == S_DRIVE);
      blank    = ((LZB != 0) && (idx == DIG_HH_T) && (snap_hh[7:4] == 4'd0)) ||
                 (blink_phase && field_blink(disp.i_blink_en, idx));
      seg_nx   = (driving && !blank) ? pattern : SEG_OFF;
      seg_nx   = seg_nx ^ SEG_XOR;
      dp_nx    = (driving && disp.i_colon && ((idx == DIG_HH_U) || (idx == DIG_MM_U))) ^ DP_XOR;
      an_nx    = driving ? (6'd1 << idx) : 6'd0;
      an_nx    = an_nx ^ AN_XOR;
      frame_nx = (state == S_LOAD);
   end

   // Pins are registered so every output changes one cycle after state/idx.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         seg_q   <= SEG_XOR;
         dp_q    <= DP_XOR;
         an_q    <= AN_XOR;
         frame_q <= 1'b0;
      end else begin
         seg_q   <= seg_nx;
         dp_q    <= dp_nx;
         an_q    <= an_nx;
         frame_q <= frame_nx;
      end
   end

   assign disp.o_seg         = seg_q;
   assign disp.o_dp          = dp_q;
   assign disp.o_an          = an_q;
   assign disp.o_frame_start = frame_q;

endmodule
`default_nettype wire
